tcam_scan: RTL and testbench
============================

Name: tcam_scan

Overview:
- Parametrised ternary CAM, successor to the single-cycle x-based TCAM.
- Each entry holds a value, an explicit don't-care mask and a valid bit. Entries never rely on simulation x values.
- Searches scan LANES entries per cycle under a ready/valid handshake. Result: hit flag, most-specific matching index and number of matching entries.
- Also supports write, single-entry invalidate and full flush. Sits in front of lookup/classification logic as a shared lookup engine.

Parameters:
- KEY_W, 8, key/entry width in bits.
- ADDR_W, 5, index width; DEPTH = 2**ADDR_W entries.
- LANES, 4, entries compared per scan cycle. Must be a power of two and ≤ DEPTH. N = DEPTH/LANES scan cycles.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- op_valid, input, 1, operation request.
- op_ready, output, 1, block can accept an operation; high only in IDLE.
- op_code, input, 2, 00 search, 01 write, 10 invalidate, 11 flush.
- op_addr, input, ADDR_W, entry index for write/invalidate.
- op_key, input, KEY_W, write value or search key.
- op_mask, input, KEY_W, 1 = don't care. Applies to the stored mask on write and to the key on search.
- res_valid, output, 1, one-cycle pulse, search result present.
- res_hit, output, 1, at least one entry matched.
- res_addr, output, ADDR_W, selected matching index (0 if no hit).
- res_count, output, ADDR_W+1, number of matching entries (0..DEPTH).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All valid bits cleared; FSM to IDLE.
  - op_ready=1, res_valid=0, res_hit=0, res_addr=0, res_count=0.
  - Entry value/mask storage is not reset.
  - Reset mid-search aborts the search; no res_valid is produced for it.
- Handshake: an operation is accepted at an edge where op_valid && op_ready. Inputs are sampled only at acceptance.
- FSM states: IDLE, SCAN, DONE.
  - IDLE, accepted write: value[op_addr] = op_key & ~op_mask, mask[op_addr] = op_mask, valid[op_addr] = 1. Completes in 1 cycle; stays IDLE.
  - IDLE, accepted invalidate: valid[op_addr] = 0; stays IDLE. Value and mask are untouched.
  - IDLE, accepted flush: all valid bits = 0 in one edge; stays IDLE.
  - IDLE, accepted search: latch key and key mask; clear scan index, best candidate and count; go to SCAN.
  - SCAN: each cycle, compare entries [i*LANES, i*LANES+LANES-1] for i = 0..N-1. After the N-th scan edge, go to DONE.
  - DONE: res_valid=1 for exactly this cycle; next edge returns to IDLE.
- Latency: search accepted at edge E → res_valid high in the cycle following edge E+N. op_ready is low from E until DONE exits at edge E+N+1. Back-to-back searches are therefore N+2 cycles apart.
- Match rule for entry e, every bit b must satisfy at least one of:
  - mask[e][b] = 1;
  - key_mask[b] = 1;
  - value[e][b] == key[b].
  - The entry must also have valid[e] = 1.
- Selection rule:
  - Prefer the matching entry with the fewest stored don't-care bits (popcount of mask[e]).
  - Ties go to the lowest index, including ties between lanes within one scan cycle.
- res_count: total number of matches, saturating impossible since max is DEPTH and the width is ADDR_W+1.
- Result outputs hold their values until the next search reaches DONE. res_hit = (res_count != 0).
- Write and invalidate on the same index in separate operations behave strictly in order. No op can overlap a search because op_ready=0.
- op_valid while op_ready=0 is ignored. The requester must hold its request until accepted.
- Key mask of all ones: every valid entry matches. The entry with the fewest stored don't-care bits, then the lowest index, is selected.

Test Plan:
- Reset, then search key 8'h5A, mask 0 → res_valid after E+8 (N=8 with defaults), res_hit=0, res_count=0, res_addr=0.
- Write idx 3 = 8'h5A/mask 8'h00; write idx 7 = 8'h50/mask 8'h0F; search 8'h5A → hit, res_addr=3, res_count=2. Then invalidate 3 and search again → res_addr=7, res_count=1.
- Write idx 9 and idx 4 both 8'hA0/mask 8'h03; search 8'hA2 → res_addr=4 (tie, lower index), res_count=2.
- Write idx 0 = 8'h00/mask 8'hFF and idx 31 = 8'h11/mask 8'h00; search 8'h11 → res_addr=31, res_count=2. Search 8'h22 → res_addr=0, res_count=1.
- Start a search, drive op_valid write for 3 cycles during SCAN → op_ready=0 and the write is not applied until IDLE. Assert rst_n=0 at the 4th scan cycle → no res_valid, all outputs at reset values, later searches miss.
- Write 32 entries, flush, search with mask 8'hFF → res_hit=0, res_count=0.

Source files
------------

// File: rtl/tcam_scan.sv
// Ternary CAM with explicit per-entry don't-care masks; searches scan LANES
// entries per cycle and report hit, most-specific index and match count.
module tcam_scan #(
    parameter int KEY_W  = 8,
    parameter int ADDR_W = 5,
    parameter int LANES  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [KEY_W-1:0]  op_key,
    input  logic [KEY_W-1:0]  op_mask,
    output logic              res_valid,
    output logic              res_hit,
    output logic [ADDR_W-1:0] res_addr,
    output logic [ADDR_W:0]   res_count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int N     = DEPTH / LANES;
    localparam int PC_W  = $clog2(KEY_W + 1);
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [1:0] OP_SEARCH = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_INVAL  = 2'b10;
    localparam logic [1:0] OP_FLUSH  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [KEY_W-1:0]   value_r [DEPTH];
    logic [KEY_W-1:0]   mask_r  [DEPTH];
    logic [DEPTH-1:0]   valid_r;
    logic [KEY_W-1:0]   key_r, kmask_r;
    logic [ADDR_W-1:0]  scan_idx_r;
    logic               best_found_r;
    logic [ADDR_W-1:0]  best_addr_r;
    logic [PC_W-1:0]    best_pc_r;
    logic [CNT_W-1:0]   count_r;
    logic               op_ready_r, res_valid_r, res_hit_r;
    logic [ADDR_W-1:0]  res_addr_r;
    logic [CNT_W-1:0]   res_count_r;

    logic [ADDR_W-1:0]  lane_addr_s  [LANES];
    logic               lane_match_s [LANES];
    logic [PC_W-1:0]    lane_pc_s    [LANES];
    logic               cand_found_s;
    logic [ADDR_W-1:0]  cand_addr_s;
    logic [PC_W-1:0]    cand_pc_s;
    logic [CNT_W-1:0]   count_next_s;
    logic               accept_s, last_s;

    function automatic logic [PC_W-1:0] popcount(input logic [KEY_W-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int b = 0; b < KEY_W; b++) c = c + PC_W'(v[b]);
        return c;
    endfunction

    function automatic logic entry_match(input logic vld, input logic [KEY_W-1:0] val,
                                         input logic [KEY_W-1:0] msk, input logic [KEY_W-1:0] key,
                                         input logic [KEY_W-1:0] kmsk);
        return vld & (&(msk | kmsk | ~(val ^ key)));
    endfunction

    assign accept_s  = op_valid && op_ready_r;
    assign last_s    = (scan_idx_r == ADDR_W'(N - 1));
    assign op_ready  = op_ready_r;
    assign res_valid = res_valid_r;
    assign res_hit   = res_hit_r;
    assign res_addr  = res_addr_r;
    assign res_count = res_count_r;

    // Per-lane compare of the entries covered by the current scan slice.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_addr_s[l]  = ADDR_W'(int'(scan_idx_r) * LANES + l);
            lane_match_s[l] = entry_match(valid_r[lane_addr_s[l]], value_r[lane_addr_s[l]],
                                          mask_r[lane_addr_s[l]], key_r, kmask_r);
            lane_pc_s[l]    = popcount(mask_r[lane_addr_s[l]]);
        end
    end

    // Fold lanes into the running best; strict less-than keeps the lowest index on ties.
    always_comb begin
        cand_found_s = best_found_r;
        cand_addr_s  = best_addr_r;
        cand_pc_s    = best_pc_r;
        count_next_s = count_r;
        for (int l = 0; l < LANES; l++) begin
            count_next_s = count_next_s + CNT_W'(lane_match_s[l]);
            if (lane_match_s[l] && (!cand_found_s || (lane_pc_s[l] < cand_pc_s))) begin
                cand_found_s = 1'b1;
                cand_addr_s  = lane_addr_s[l];
                cand_pc_s    = lane_pc_s[l];
            end else begin
                cand_found_s = cand_found_s;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (op_code == OP_SEARCH)) state_s = ST_SCAN;
                else                                    state_s = ST_IDLE;
            end
            ST_SCAN: begin
                if (last_s) state_s = ST_DONE;
                else        state_s = ST_SCAN;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Control, valid bits, scan accumulators and registered results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            valid_r      <= '0;
            key_r        <= '0;
            kmask_r      <= '0;
            scan_idx_r   <= '0;
            best_found_r <= 1'b0;
            best_addr_r  <= '0;
            best_pc_r    <= '0;
            count_r      <= '0;
            op_ready_r   <= 1'b1;
            res_valid_r  <= 1'b0;
            res_hit_r    <= 1'b0;
            res_addr_r   <= '0;
            res_count_r  <= '0;
        end else begin
            state_r     <= state_s;
            op_ready_r  <= (state_s == ST_IDLE);
            res_valid_r <= (state_r == ST_SCAN) && last_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        case (op_code)
                            OP_WRITE: valid_r[op_addr] <= 1'b1;
                            OP_INVAL: valid_r[op_addr] <= 1'b0;
                            OP_FLUSH: valid_r          <= '0;
                            default: begin
                                key_r        <= op_key;
                                kmask_r      <= op_mask;
                                scan_idx_r   <= '0;
                                best_found_r <= 1'b0;
                                best_addr_r  <= '0;
                                best_pc_r    <= '0;
                                count_r      <= '0;
                            end
                        endcase
                    end
                end
                ST_SCAN: begin
                    scan_idx_r   <= scan_idx_r + ADDR_W'(1);
                    best_found_r <= cand_found_s;
                    best_addr_r  <= cand_addr_s;
                    best_pc_r    <= cand_pc_s;
                    count_r      <= count_next_s;
                    if (last_s) begin
                        res_hit_r   <= (count_next_s != '0);
                        res_addr_r  <= cand_addr_s;
                        res_count_r <= count_next_s;
                    end
                end
                default: ;
            endcase
        end
    end

    // Entry value/mask storage; deliberately not reset, guarded by valid_r.
    always_ff @(posedge clk) begin
        if (accept_s && (op_code == OP_WRITE)) begin
            value_r[op_addr] <= op_key & ~op_mask;
            mask_r[op_addr]  <= op_mask;
        end
    end
endmodule

// File: tb/tb_tcam_scan.sv
// Scoreboard bench for tcam_scan: searches push expected results, a monitor
// pops and compares them (including latency) whenever res_valid pulses.
module tb_tcam_scan;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [1:0] op_code;
    logic [4:0] op_addr;
    logic [7:0] op_key, op_mask;
    logic       res_valid, res_hit;
    logic [4:0] res_addr;
    logic [5:0] res_count;

    typedef struct packed {
        logic       hit;
        logic [4:0] addr;
        logic [5:0] count;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    tcam_scan dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_addr(op_addr), .op_key(op_key), .op_mask(op_mask),
        .res_valid(res_valid), .res_hit(res_hit), .res_addr(res_addr), .res_count(res_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (res_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_res: res_valid with no search outstanding at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res_hit", int'(res_hit), int'(e.hit));
                chk("res_addr", int'(res_addr), int'(e.addr));
                chk("res_count", int'(res_count), int'(e.count));
                chk("res_latency", cyc, e.cyc);
            end
        end
    end

    // Issue one op; searches push their expected result when push is set.
    task automatic issue(input logic [1:0] code, input logic [4:0] addr, input logic [7:0] key,
                         input logic [7:0] mask, input logic push, input logic ehit,
                         input logic [4:0] eaddr, input logic [5:0] ecount);
        exp_t e;
        @(negedge clk);
        op_valid = 1'b1; op_code = code; op_addr = addr; op_key = key; op_mask = mask;
        for (int k = 0; k < 100 && !op_ready; k++) @(negedge clk);
        if (!op_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: op_ready stuck at %0d expected 1", op_ready);
        end
        @(negedge clk);
        op_valid = 1'b0;
        if (push) begin
            e.hit = ehit; e.addr = eaddr; e.count = ecount; e.cyc = cyc + 8;
            exp_q.push_back(e);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] v, input logic [7:0] m);
        issue(2'b01, a, v, m, 1'b0, 1'b0, 5'd0, 6'd0);
    endtask

    task automatic srch(input logic [7:0] k, input logic [7:0] m, input logic h,
                        input logic [4:0] a, input logic [5:0] c);
        issue(2'b00, 5'd0, k, m, 1'b1, h, a, c);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_op_ready"}, int'(op_ready), 1);
        chk({tag, "_res_valid"}, int'(res_valid), 0);
        chk({tag, "_res_hit"}, int'(res_hit), 0);
        chk({tag, "_res_addr"}, int'(res_addr), 0);
        chk({tag, "_res_count"}, int'(res_count), 0);
    endtask

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; op_code = 2'b00; op_addr = 5'd0; op_key = 8'h00; op_mask = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("reset");

        srch(8'h5A, 8'h00, 1'b0, 5'd0, 6'd0);

        wr(5'd3, 8'h5A, 8'h00);
        wr(5'd7, 8'h50, 8'h0F);
        srch(8'h5A, 8'h00, 1'b1, 5'd3, 6'd2);
        issue(2'b10, 5'd3, 8'h00, 8'h00, 1'b0, 1'b0, 5'd0, 6'd0);
        srch(8'h5A, 8'h00, 1'b1, 5'd7, 6'd1);

        wr(5'd9, 8'hA0, 8'h03);
        wr(5'd4, 8'hA0, 8'h03);
        srch(8'hA2, 8'h00, 1'b1, 5'd4, 6'd2);

        wr(5'd0, 8'h00, 8'hFF);
        wr(5'd31, 8'h11, 8'h00);
        srch(8'h11, 8'h00, 1'b1, 5'd31, 6'd2);
        srch(8'h22, 8'h00, 1'b1, 5'd0, 6'd1);
        // Entries 0,4,7,9,31 valid; 31 has no don't-cares so it wins a full-wildcard key.
        srch(8'h00, 8'hFF, 1'b1, 5'd31, 6'd5);

        // Search that gets aborted by reset during its 4th scan edge.
        issue(2'b00, 5'd0, 8'h11, 8'h00, 1'b0, 1'b0, 5'd0, 6'd0);
        for (int k = 0; k < 3; k++) begin
            op_valid = 1'b1; op_code = 2'b01; op_addr = 5'd5; op_key = 8'h77; op_mask = 8'h00;
            chk("scan_op_ready", int'(op_ready), 0);
            @(negedge clk);
        end
        op_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("abort");
        srch(8'h77, 8'h00, 1'b0, 5'd0, 6'd0);
        srch(8'h00, 8'hFF, 1'b0, 5'd0, 6'd0);

        for (int i = 0; i < 32; i++) wr(5'(i), 8'(i), 8'h00);
        srch(8'h00, 8'hFF, 1'b1, 5'd0, 6'd32);
        srch(8'h13, 8'h00, 1'b1, 5'd19, 6'd1);
        issue(2'b11, 5'd0, 8'h00, 8'h00, 1'b0, 1'b0, 5'd0, 6'd0);
        srch(8'h00, 8'hFF, 1'b0, 5'd0, 6'd0);

        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: %0d results outstanding expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
